// File: rtl/ucode_sequencer.sv
// Microcoded control unit: latches an opcode, maps it through a writable decode
// table to a start micro-address, then steps a writable microcode store.
module ucode_sequencer #(
    parameter int unsigned OP_W               = 8,
    parameter int unsigned STATE_W            = 6,
    parameter int unsigned CTRL_W             = 16,
    parameter logic [CTRL_W-1:0]  FETCH_CTRL  = CTRL_W'(16'h0001),
    parameter logic [STATE_W-1:0] IRQ_STATE   = STATE_W'(6'h3F),
    localparam int unsigned PA_W              = (OP_W > STATE_W) ? OP_W : STATE_W,
    localparam int unsigned PD_W              = CTRL_W + STATE_W + 2
) (
    input  logic                ph1,
    input  logic                reset,
    input  logic [OP_W-1:0]     data_in,
    input  logic                op_en,
    input  logic                stall,
    input  logic                cond,
    input  logic                irq,
    input  logic                prog_we,
    input  logic                prog_sel,
    input  logic [PA_W-1:0]     prog_addr,
    input  logic [PD_W-1:0]     prog_data,
    output logic [CTRL_W-1:0]   controls,
    output logic [OP_W-1:0]     opcode,
    output logic [STATE_W-1:0]  upc,
    output logic                instr_done,
    output logic                irq_ack
);

    localparam int unsigned UC_DEPTH  = 2 ** STATE_W;
    localparam int unsigned DEC_DEPTH = 2 ** OP_W;

    typedef enum logic [0:0] {
        FETCH = 1'b0,
        EXEC  = 1'b1
    } state_t;

    typedef enum logic [1:0] {
        M_SEQ = 2'b00,
        M_JMP = 2'b01,
        M_BR  = 2'b10,
        M_END = 2'b11
    } mode_t;

    logic [PD_W-1:0]    ucode [UC_DEPTH];
    logic [STATE_W-1:0] dec   [DEC_DEPTH];

    state_t             state, state_n;
    logic [STATE_W-1:0] upc_n;
    logic [OP_W-1:0]    opcode_n;
    logic               instr_done_n;
    logic               irq_ack_n;

    logic [PD_W-1:0]    entry_c;
    logic [CTRL_W-1:0]  u_ctrl_c;
    logic [STATE_W-1:0] u_next_c;
    mode_t              u_mode_c;
    logic [STATE_W-1:0] upc_inc_c;

    // Current micro-op fields; read is asynchronous so a same-cycle write is not seen
    assign entry_c   = ucode[upc];
    assign u_ctrl_c  = entry_c[PD_W-1 -: CTRL_W];
    assign u_next_c  = entry_c[STATE_W+1:2];
    assign u_mode_c  = mode_t'(entry_c[1:0]);
    assign upc_inc_c = upc + STATE_W'(1);

    assign controls  = (state == EXEC) ? u_ctrl_c : FETCH_CTRL;

    // Store programming port; stores are deliberately left out of reset
    always_ff @(posedge ph1) begin
        if (prog_we) begin
            if (prog_sel) begin
                dec[OP_W'(prog_addr)] <= prog_data[STATE_W-1:0];
            end else begin
                ucode[STATE_W'(prog_addr)] <= prog_data;
            end
        end
    end

    always_ff @(posedge ph1 or posedge reset) begin
        if (reset) begin
            state      <= FETCH;
            upc        <= '0;
            opcode     <= '0;
            instr_done <= 1'b0;
            irq_ack    <= 1'b0;
        end else begin
            state      <= state_n;
            upc        <= upc_n;
            opcode     <= opcode_n;
            instr_done <= instr_done_n;
            irq_ack    <= irq_ack_n;
        end
    end

    // Next-state: stall holds everything and drops the pulses
    always_comb begin
        state_n      = state;
        upc_n        = upc;
        opcode_n     = opcode;
        instr_done_n = 1'b0;
        irq_ack_n    = 1'b0;

        if (!stall) begin
            unique case (state)
                FETCH: begin
                    if (op_en) begin
                        opcode_n = data_in;
                        upc_n    = dec[data_in];
                        state_n  = EXEC;
                    end
                end
                EXEC: begin
                    unique case (u_mode_c)
                        M_SEQ: upc_n = upc_inc_c;
                        M_JMP: upc_n = u_next_c;
                        M_BR:  upc_n = cond ? u_next_c : upc_inc_c;
                        M_END: begin
                            instr_done_n = 1'b1;
                            // Interrupt entry only at an instruction boundary
                            if (irq) begin
                                upc_n     = IRQ_STATE;
                                irq_ack_n = 1'b1;
                            end else begin
                                state_n = FETCH;
                            end
                        end
                        default: upc_n = upc;
                    endcase
                end
                default: state_n = FETCH;
            endcase
        end
    end

endmodule

// File: tb/tb_ucode_sequencer.sv
// Randomised self-checking bench for ucode_sequencer against a behavioural model,
// with directed scenarios pinned by hand-computed literal expectations.
module tb_ucode_sequencer;

    logic        ph1 = 1'b0;
    logic        reset = 1'b1;
    logic [7:0]  data_in = '0;
    logic        op_en = 1'b0;
    logic        stall = 1'b0;
    logic        cond = 1'b0;
    logic        irq = 1'b0;
    logic        prog_we = 1'b0;
    logic        prog_sel = 1'b0;
    logic [7:0]  prog_addr = '0;
    logic [23:0] prog_data = '0;
    logic [15:0] controls;
    logic [7:0]  opcode;
    logic [5:0]  upc;
    logic        instr_done;
    logic        irq_ack;

    ucode_sequencer dut (
        .ph1        (ph1),
        .reset      (reset),
        .data_in    (data_in),
        .op_en      (op_en),
        .stall      (stall),
        .cond       (cond),
        .irq        (irq),
        .prog_we    (prog_we),
        .prog_sel   (prog_sel),
        .prog_addr  (prog_addr),
        .prog_data  (prog_data),
        .controls   (controls),
        .opcode     (opcode),
        .upc        (upc),
        .instr_done (instr_done),
        .irq_ack    (irq_ack)
    );

    always #5 ph1 = ~ph1;

    int n_tests = 0;
    int n_fail  = 0;
    bit chk_en  = 1'b0;

    // Behavioural model
    logic [23:0] m_uc  [64];
    logic [5:0]  m_dec [256];
    bit          m_fetch = 1'b1;
    logic [5:0]  m_upc = '0;
    logic [7:0]  m_opcode = '0;
    bit          m_done = 1'b0;
    bit          m_ack = 1'b0;

    function automatic logic [23:0] ent(input logic [15:0] c, input logic [5:0] nx, input logic [1:0] md);
        return {c, nx, md};
    endfunction

    function automatic logic [15:0] exp_ctrl();
        logic [23:0] e;
        e = m_uc[m_upc];
        return m_fetch ? 16'h0001 : e[23:8];
    endfunction

    always @(posedge ph1 or posedge reset) begin : model_p
        logic [23:0] e;
        if (reset) begin
            m_fetch = 1'b1; m_upc = '0; m_opcode = '0; m_done = 1'b0; m_ack = 1'b0;
        end else begin
            e = m_uc[m_upc];
            m_done = 1'b0;
            m_ack  = 1'b0;
            if (!stall) begin
                if (m_fetch) begin
                    if (op_en) begin
                        m_opcode = data_in;
                        m_upc    = m_dec[data_in];
                        m_fetch  = 1'b0;
                    end
                end else begin
                    case (e[1:0])
                        2'd0: m_upc = 6'(m_upc + 6'd1);
                        2'd1: m_upc = e[7:2];
                        2'd2: m_upc = cond ? e[7:2] : 6'(m_upc + 6'd1);
                        default: begin
                            m_done = 1'b1;
                            if (irq) begin
                                m_upc = 6'h3F;
                                m_ack = 1'b1;
                            end else begin
                                m_fetch = 1'b1;
                            end
                        end
                    endcase
                end
            end
            if (prog_we) begin
                if (prog_sel) m_dec[prog_addr] = prog_data[5:0];
                else          m_uc[prog_addr[5:0]] = prog_data;
            end
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %h expected %h", nm, $time, act, exp);
        end
    endtask

    // Per-cycle comparison against the model
    always @(negedge ph1) begin
        if (chk_en) begin
            chk("m_controls",   32'(controls),   32'(exp_ctrl()));
            chk("m_upc",        32'(upc),        32'(m_upc));
            chk("m_opcode",     32'(opcode),     32'(m_opcode));
            chk("m_instr_done", 32'(instr_done), 32'(m_done));
            chk("m_irq_ack",    32'(irq_ack),    32'(m_ack));
        end
    end

    task automatic tick();
        @(posedge ph1);
        @(negedge ph1);
        #1;
    endtask

    task automatic prog(input logic sel, input logic [7:0] a, input logic [23:0] d);
        prog_we = 1'b1; prog_sel = sel; prog_addr = a; prog_data = d;
        tick();
        prog_we = 1'b0;
    endtask

    task automatic issue(input logic [7:0] op);
        op_en = 1'b1; data_in = op;
        tick();
        op_en = 1'b0;
    endtask

    initial begin
        tick();
        tick();
        chk_en = 1'b1;
        chk("rst_controls", 32'(controls), 32'h0001);
        chk("rst_upc",      32'(upc),      32'h0);
        chk("rst_done",     32'(instr_done), 32'h0);
        reset = 1'b0;
        tick();

        // Fill both stores with random content, END-biased
        for (int i = 0; i < 256; i++) prog(1'b1, 8'(i), 24'($urandom));
        for (int i = 0; i < 64; i++) begin
            int r;
            logic [1:0] md;
            r  = $urandom_range(0, 9);
            md = (r < 4) ? 2'd3 : (r < 6) ? 2'd0 : (r < 8) ? 2'd1 : 2'd2;
            prog(1'b0, 8'(i), {16'($urandom), 6'($urandom), md});
        end

        prog(1'b1, 8'h01, 24'h04);
        prog(1'b0, 8'h04, ent(16'h0010, 6'h00, 2'd0));
        prog(1'b0, 8'h05, ent(16'h0020, 6'h00, 2'd3));
        prog(1'b1, 8'h02, 24'h08);
        prog(1'b0, 8'h08, ent(16'h0040, 6'h0C, 2'd2));
        prog(1'b0, 8'h09, ent(16'h0080, 6'h00, 2'd3));
        prog(1'b0, 8'h0C, ent(16'h0100, 6'h00, 2'd3));
        prog(1'b0, 8'h3F, ent(16'h0400, 6'h00, 2'd3));

        // Basic SEQ then END
        chk("a_fetch", 32'(controls), 32'h0001);
        issue(8'h01);
        chk("a_ctrl0", 32'(controls), 32'h0010);
        chk("a_upc0",  32'(upc),      32'h04);
        chk("a_op",    32'(opcode),   32'h01);
        tick();
        chk("a_ctrl1", 32'(controls), 32'h0020);
        tick();
        chk("a_ctrl2", 32'(controls), 32'h0001);
        chk("a_done",  32'(instr_done), 32'h1);
        tick();
        chk("a_done_drop", 32'(instr_done), 32'h0);

        // Branch taken and not taken
        cond = 1'b1;
        issue(8'h02);
        chk("b_ctrl", 32'(controls), 32'h0040);
        tick();
        chk("b_taken", 32'(controls), 32'h0100);
        cond = 1'b0;
        tick();
        issue(8'h02);
        tick();
        chk("b_not_taken", 32'(controls), 32'h0080);
        tick();
        tick();

        // Stall holds everything
        issue(8'h01);
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("c_stall_ctrl", 32'(controls), 32'h0010);
            chk("c_stall_upc",  32'(upc),      32'h04);
        end
        stall = 1'b0;
        tick();
        chk("c_resume", 32'(controls), 32'h0020);

        // Interrupt taken at END, no FETCH in between
        irq = 1'b1;
        tick();
        chk("d_ack",  32'(irq_ack),  32'h1);
        chk("d_done", 32'(instr_done), 32'h1);
        chk("d_upc",  32'(upc),      32'h3F);
        chk("d_ctrl", 32'(controls), 32'h0400);
        irq = 1'b0;
        tick();
        chk("d_ret",  32'(controls), 32'h0001);
        chk("d_ack_drop", 32'(irq_ack), 32'h0);
        tick();

        // Rewrite the executing micro-op: old data now, new data next pass
        issue(8'h01);
        tick();
        chk("e_old", 32'(controls), 32'h0020);
        prog(1'b0, 8'h05, ent(16'h0200, 6'h00, 2'd3));
        issue(8'h01);
        tick();
        chk("e_new", 32'(controls), 32'h0200);
        tick();

        // SEQ wraps from 3F to 00
        prog(1'b1, 8'h03, 24'h3F);
        prog(1'b0, 8'h3F, ent(16'h0400, 6'h00, 2'd0));
        prog(1'b0, 8'h00, ent(16'h0800, 6'h00, 2'd3));
        issue(8'h03);
        chk("f_upc3f", 32'(upc), 32'h3F);
        tick();
        chk("f_wrap_upc",  32'(upc),      32'h00);
        chk("f_wrap_ctrl", 32'(controls), 32'h0800);
        tick();

        // Asynchronous reset mid-instruction; stores retained
        issue(8'h01);
        reset = 1'b1;
        #1;
        chk("g_rst_ctrl", 32'(controls), 32'h0001);
        chk("g_rst_upc",  32'(upc),      32'h0);
        chk("g_rst_op",   32'(opcode),   32'h0);
        chk("g_rst_done", 32'(instr_done), 32'h0);
        tick();
        reset = 1'b0;
        issue(8'h01);
        chk("g_retain", 32'(controls), 32'h0010);
        tick();
        chk("g_retain2", 32'(controls), 32'h0200);
        tick();

        // Randomised traffic
        for (int i = 0; i < 3000; i++) begin
            reset     = ($urandom_range(0, 99) == 0);
            op_en     = 1'($urandom_range(0, 1));
            data_in   = 8'($urandom);
            stall     = ($urandom_range(0, 99) < 15);
            cond      = 1'($urandom_range(0, 1));
            irq       = ($urandom_range(0, 99) < 10);
            prog_we   = !reset && ($urandom_range(0, 99) < 5);
            prog_sel  = 1'($urandom_range(0, 1));
            prog_addr = 8'($urandom);
            prog_data = 24'($urandom);
            tick();
        end
        reset = 1'b0; prog_we = 1'b0; op_en = 1'b0; stall = 1'b0; irq = 1'b0;
        tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
